// File: rtl/mc_ctrl_pkg.sv
// Encodings shared by the multi-cycle control unit:
// opcodes, funcs, ALU ops, FSM states and mux selects.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [3:0] S_IFETCH = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_ctr;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_mem_state(
    input logic [3:0] s
  );
    return (s == S_IFETCH) ||
           (s == S_MEMRD) ||
           (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Bundle between the control unit and the
// multi-cycle datapath / memory.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
) ();

  logic [5:0]       op;
  logic [5:0]       func;
  logic             mem_ready;
  logic             PCWr;
  logic             PCWrCond;
  logic             IorD;
  logic             MemRd;
  logic             MemWr;
  logic             IRWr;
  logic             RegWr;
  logic             RegDst;
  logic             MemtoReg;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             ExtOp;
  logic [2:0]       ALUctr;
  logic [1:0]       PCSrc;
  logic [3:0]       state;
  logic             illegal;
  logic             timeout;
  logic             halted;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, func, mem_ready,
    output PCWr, PCWrCond, IorD, MemRd,
    output MemWr, IRWr, RegWr, RegDst,
    output MemtoReg, ALUSrcA, ALUSrcB,
    output ExtOp, ALUctr, PCSrc, state,
    output illegal, timeout, halted,
    output instret
  );

  modport slave (
    output op, func, mem_ready,
    input  PCWr, PCWrCond, IorD, MemRd,
    input  MemWr, IRWr, RegWr, RegDst,
    input  MemtoReg, ALUSrcA, ALUSrcB,
    input  ExtOp, ALUctr, PCSrc, state,
    input  illegal, timeout, halted,
    input  instret
  );

endinterface

// File: rtl/mc_alu_dec.sv
// R-type func decoder: ALU operation plus a
// legality bit for trapping unknown funcs.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] func_i,
  output logic [2:0] alu_ctr_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctr_o = ALU_ADDU;
    valid_o   = 1'b1;
    case (func_i)
      FN_ADD:  alu_ctr_o = ALU_ADD;
      FN_ADDU: alu_ctr_o = ALU_ADDU;
      FN_SUB:  alu_ctr_o = ALU_SUB;
      FN_SUBU: alu_ctr_o = ALU_SUBU;
      FN_AND:  alu_ctr_o = ALU_AND;
      FN_OR:   alu_ctr_o = ALU_OR;
      FN_SLT:  alu_ctr_o = ALU_SLT;
      FN_SLTU: alu_ctr_o = ALU_SLTU;
      default: valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore FSM sequencing a MIPS-subset multi-cycle
// datapath, with memory wait timeout and traps.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int WAIT_MAX      = 15,
  parameter int CNT_W         = 32
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM =
    WW'(WAIT_MAX);

  logic [3:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             done;
  logic             mem_st;
  logic             tmo_hit;
  logic [2:0]       fn_alu;
  logic             fn_valid;
  ctrl_t            c;

  logic is_r, is_lw, is_sw, is_beq;
  logic is_j, is_ori, is_addiu;

  assign is_r     = bus.op == OP_RTYPE;
  assign is_lw    = bus.op == OP_LW;
  assign is_sw    = bus.op == OP_SW;
  assign is_beq   = bus.op == OP_BEQ;
  assign is_j     = bus.op == OP_J;
  assign is_ori   = bus.op == OP_ORI;
  assign is_addiu = bus.op == OP_ADDIU;

  mc_alu_dec u_alu_dec (
    .func_i    (bus.func),
    .alu_ctr_o (fn_alu),
    .valid_o   (fn_valid)
  );

  // Without handshake every memory access
  // completes in its first cycle.
  assign done    = !MEM_HANDSHAKE || bus.mem_ready;
  assign mem_st  = is_mem_state(state_q);
  assign tmo_hit = MEM_HANDSHAKE && mem_st &&
                   !bus.mem_ready &&
                   (wait_q == WAIT_LIM);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    wait_d    = '0;
    retire    = 1'b0;
    case (state_q)
      S_IFETCH: if (done) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw:
            state_d = S_MEMADR;
          is_r && fn_valid:
            state_d = S_EXEC;
          is_beq:
            state_d = S_BRANCH;
          is_j:
            state_d = S_JUMP;
          is_ori, is_addiu:
            state_d = S_IEXEC;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:
        state_d = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD: if (done) state_d = S_MEMWB;
      S_MEMWB: begin
        retire  = 1'b1;
        state_d = S_IFETCH;
      end
      S_MEMWR: if (done) begin
        retire  = 1'b1;
        state_d = S_IFETCH;
      end
      S_EXEC:  state_d = S_RWB;
      S_IEXEC: state_d = S_IWB;
      S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
        retire  = 1'b1;
        state_d = S_IFETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    if (tmo_hit) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end
    if (MEM_HANDSHAKE && mem_st &&
        !done && !tmo_hit)
      wait_d = wait_q + WW'(1);
  end

  always_comb begin
    c         = '0;
    c.alu_ctr = ALU_ADDU;
    case (state_q)
      S_IFETCH: begin
        c.mem_rd    = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_wr     = done;
        c.pc_wr     = done;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_BOFS;
        c.ext_op    = 1'b1;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.ext_op    = 1'b1;
      end
      S_MEMRD: begin
        c.mem_rd = 1'b1;
        c.i_or_d = 1'b1;
      end
      S_MEMWB: begin
        c.reg_wr     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_wr = 1'b1;
        c.i_or_d = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_ctr   = fn_alu;
      end
      S_RWB: begin
        c.reg_wr  = 1'b1;
        c.reg_dst = 1'b1;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.ext_op    = !is_ori;
        c.alu_ctr   = is_ori ? ALU_OR : ALU_ADDU;
      end
      S_IWB: c.reg_wr = 1'b1;
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_RT;
        c.alu_ctr    = ALU_SUBU;
        c.pc_wr_cond = 1'b1;
        c.pc_src     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_wr  = 1'b1;
        c.pc_src = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IFETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      if (retire)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.PCWr     = c.pc_wr;
  assign bus.PCWrCond = c.pc_wr_cond;
  assign bus.IorD     = c.i_or_d;
  assign bus.MemRd    = c.mem_rd;
  assign bus.MemWr    = c.mem_wr;
  assign bus.IRWr     = c.ir_wr;
  assign bus.RegWr    = c.reg_wr;
  assign bus.RegDst   = c.reg_dst;
  assign bus.MemtoReg = c.mem_to_reg;
  assign bus.ALUSrcA  = c.alu_src_a;
  assign bus.ALUSrcB  = c.alu_src_b;
  assign bus.ExtOp    = c.ext_op;
  assign bus.ALUctr   = c.alu_ctr;
  assign bus.PCSrc    = c.pc_src;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal_q;
  assign bus.timeout  = timeout_q;
  assign bus.halted   = state_q == S_TRAP;
  assign bus.instret  = instret_q;

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle successor to the single-cycle control unit: a Moore FSM that sequences each MIPS-subset instruction through fetch, decode, execute, memory and writeback over 3-5 cycles. It drives a shared-memory, single-ALU multi-cycle datapath. Over the single-cycle design it adds:
- an optional ready/valid memory handshake with timeout;
- illegal-instruction trapping;
- a retired-instruction counter.

## Interface
Parameters:
- MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = memory always completes in one cycle and mem_ready is ignored.
- WAIT_MAX, default 15: maximum wait cycles per memory access before timeout; must be ≥1.
- CNT_W, default 32: width of the retired-instruction counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26], taken from the datapath instruction register.
- func  in  6  IR[5:0].
- mem_ready  in  1  memory access completes this cycle.
- PCWr  out  1  unconditional PC write.
- PCWrCond  out  1  PC write qualified by ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRd  out  1  memory read request.
- MemWr  out  1  memory write request.
- IRWr  out  1  instruction register write.
- RegWr  out  1  register-file write.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B operand: 00 = rt, 01 = const 4, 10 = extended imm, 11 = sign-extended imm<<2.
- ExtOp  out  1  immediate extension: 1 = sign, 0 = zero.
- ALUctr  out  3  ALU operation.
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- illegal  out  1  sticky flag: undecodable instruction.
- timeout  out  1  sticky flag: memory wait exceeded.
- halted  out  1  high while in TRAP.
- instret  out  CNT_W  count of retired instructions.

## Operation
- Supported instructions:
  - R-type (op 000000), func add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, slt 101010, sltu 101011.
  - ori 001101, addiu 001001, lw 100011, sw 101011, beq 000100, j 000010.
- ALUctr encoding: ADDU 000, ADD 001, OR 010, AND 011, SUBU 100, SUB 101, SLTU 110, SLT 111.
- States: IFETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, TRAP 12.
- Every output not listed below is 0 in every state.
- IFETCH:
  - MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=ADDU.
  - IRWr=1 and PCWr=1 only in the completing cycle (mem_ready, or always when MEM_HANDSHAKE=0).
  - On completion go to DECODE; otherwise stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=ADDU (precomputes the branch target).
  - Next state by op: lw/sw → MEMADR; R-type → EXEC; beq → BRANCH; j → JUMP; ori/addiu → IEXEC.
  - Unknown op, or R-type with unknown func → TRAP with illegal set.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=ADDU. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: MemRd=1, IorD=1. On completion → MEMWB.
- MEMWB: RegWr=1, RegDst=0, MemtoReg=1. Retires; → IFETCH.
- MEMWR: MemWr=1, IorD=1. On completion retires; → IFETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUctr from the func decode. → RWB.
- RWB: RegWr=1, RegDst=1, MemtoReg=0. Retires; → IFETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10.
  - ori: ExtOp=0, ALUctr=OR.
  - addiu: ExtOp=1, ALUctr=ADDU.
  - → IWB.
- IWB: RegWr=1, RegDst=0, MemtoReg=0. Retires; → IFETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUctr=SUBU, PCWrCond=1, PCSrc=01. Retires; → IFETCH.
- JUMP: PCWr=1, PCSrc=10. Retires; → IFETCH.
- Memory wait counter (states IFETCH, MEMRD, MEMWR; MEM_HANDSHAKE=1 only):
  - Cleared on entry to each memory state.
  - Increments each cycle mem_ready is low.
  - When the counter equals WAIT_MAX and mem_ready is still low → TRAP, timeout set, with no write enables asserted that cycle.
  - mem_ready high in the same cycle the limit is reached counts as completion; no timeout.
- TRAP: all enables 0; absorbing until reset.
- instret increments by 1 on each retiring transition and wraps modulo 2^CNT_W.

## Timing
- Reset values: state=IFETCH, illegal=0, timeout=0, instret=0, wait counter=0.
- The IFETCH outputs (MemRd=1 etc.) are valid in the first cycle after reset.
- Outputs are Moore: decoded from registered state only. Sole exception: IRWr, PCWr and the completion-gated transitions also depend on mem_ready.
- Cycles per instruction with zero wait: lw 5, sw 4, R-type 4, ori/addiu 4, beq 3, j 3. Each memory wait cycle adds 1.
- op and func are sampled only in DECODE, MEMADR, EXEC and IEXEC; the IR holds them stable after IFETCH.
- Reset asserted in any state, mid-wait included, returns to IFETCH on the next edge and clears all flags and counters.

## Structure
- Package mc_ctrl_pkg holds the opcode, func, ALUctr, state, ALUSrcB and PCSrc encodings as localparams.
- Sub-module mc_alu_dec: combinational func → {ALUctr, valid}; used in DECODE for legality and in EXEC for ALUctr.
- The FSM, wait counter, sticky flags and instret stay in multi_cycle_ctrl.

## Test plan
- MEM_HANDSHAKE=0, op=100011 (lw):
  - states 0,1,2,3,4,0;
  - RegWr=1 only in state 4;
  - instret increments once, at the end of state 4.
- R-type func=101010 (slt): ALUctr=111 in EXEC; RWB asserts RegWr=1, RegDst=1; instruction takes 4 cycles.
- beq followed by j:
  - BRANCH shows PCWrCond=1, ALUctr=100, PCSrc=01;
  - JUMP shows PCWr=1, PCSrc=10;
  - instret increases by 2.
- MEM_HANDSHAKE=1, mem_ready low for 3 cycles in MEMRD: state stays 3 for 4 cycles; MEMWB follows; timeout=0.
- WAIT_MAX=4, mem_ready held low in IFETCH: state=12, timeout=1, halted=1, IRWr never asserted; a reset pulse then returns to state 0 with flags cleared.
- op=111111: DECODE → TRAP, illegal=1, instret unchanged.
